audio_dac_tx_fifo: RTL
======================

// Module: audio_dac_tx_fifo
// PURPOSE
//   Parametrised stereo audio DAC serialiser for the theremin codec path (successor to the fixed bclk/daclrck/dacdat
//   export). Buffers stereo sample pairs from the pitch-generation Avalon-ST source in a FIFO. Shifts them out MSB-first
//   on dacdat, slaved to codec-mastered bclk/daclrck. Supports I2S and left-justified framing, with underrun reporting.
// PARAMETERS
//   DATA_W      16  bits per channel sample (8..32); slot bits beyond DATA_W are driven 0
//   FIFO_DEPTH  8   stereo pairs buffered; power of 2, >=2
//   MODE        0   0 = I2S (LRCK low = left, MSB one bclk after LRCK edge); 1 = left-justified (LRCK high = left, MSB at edge)
// PORTS
//   clk           in   1                       system clock (50 MHz); must be >= 8x bclk frequency
//   reset_n       in   1                       asynchronous active-low reset
//   asi_data      in   2*DATA_W                stereo pair: [2*DATA_W-1:DATA_W] = left, [DATA_W-1:0] = right
//   asi_valid     in   1                       pair valid
//   asi_ready     out  1                       FIFO can accept (= !full)
//   enable        in   1                       serialiser run enable
//   clr_underrun  in   1                       one-clk pulse, clears underrun flag
//   coe_bclk      in   1                       codec bit clock (async)
//   coe_daclrck   in   1                       codec DAC LR clock (async)
//   coe_dacdat    out  1                       serial DAC data
//   fifo_level    out  $clog2(FIFO_DEPTH)+1    stored pairs, 0..FIFO_DEPTH
//   underrun      out  1                       sticky: left slot started with FIFO empty while enabled
// BEHAVIOUR
//   Reset: asi_ready=1, coe_dacdat=0, fifo_level=0, underrun=0, shifter/hold regs=0, FSM=IDLE; FIFO pointers cleared.
//   Sync: bclk/daclrck each pass 2-flop synchroniser + edge-detect register; "bfall" = detected falling edge of bclk.
//     lrck is sampled only at bfall.
//     coe_dacdat updates exactly 3 clk after the bclk falling edge on the pin.
//   FIFO: push when asi_valid && asi_ready. Pop = single-cycle read at left-slot start.
//     Push+pop in the same clk leaves level unchanged.
//     No push while full (ready low); no pop while empty.
//   Slot starts (at bfall):
//     left: I2S = lrck 1->0; LJ = lrck 0->1.
//     right: the opposite lrck transition.
//   FSM states:
//     IDLE   wait for left-slot start with enable=1 -> LOAD
//     LOAD   (same bfall) pop pair into hold reg, or apply underrun rule; load left word into shifter -> SHIFT
//     SHIFT  each bfall shift one bit; at right-slot start load right half of hold reg; enable=0 at any slot start -> IDLE
//   Bit timing:
//     LJ: MSB driven at the slot-start bfall, then one bit per bfall.
//     I2S: 0 driven at slot start, MSB at the following bfall.
//     After DATA_W bits, drive 0 until the next slot start.
//     A slot shorter than DATA_W bits is truncated (LSBs dropped); a longer slot is zero-padded.
//   Underrun: left-slot start in LOAD with FIFO empty -> underrun=1 (sticky), output per CONFIGURATION, no pop.
//     clr_underrun clears the flag; a set in the same cycle as clear wins.
//   enable=0: coe_dacdat=0, no pops, FIFO still accepts pushes.
//     Re-enabling takes effect only at the next left-slot start, so no partial frames.
//   Reset mid-frame: everything returns to reset values. Output resumes at the first full left slot after release.
//   Bit-clock loss: output holds its last value. No timeout.
// CONFIGURATION
//   DAC_HOLD_LAST_EN defined:     on underrun, re-send the previous hold-register pair (last good samples, 0 after reset).
//   DAC_HOLD_LAST_EN not defined: on underrun, send an all-zero pair.
//   Flag behaviour is identical in both builds.
// TESTING
//   T1 LJ, DATA_W=16: push L=0xA5C3, R=0x1234, enable=1, bclk=3.072 MHz, 32-bit slots
//      -> dacdat: A5C3 MSB-first at the lrck-rise bfall, then 16 zeros; 1234 after the lrck fall.
//   T2 MODE=0 (I2S): same pair -> one leading 0 bit after each lrck edge, then A5C3 / 1234; left in lrck-low slot.
//   T3 Fill: push 10 pairs with no bclk -> asi_ready=0 after the 8th, fifo_level=8.
//      Run 8 frames -> samples in push order, level steps 8..0, ready returns to 1 after the first pop.
//   T4 Underrun: empty FIFO, enabled -> underrun=1 at the first left slot.
//      Output 0x0000 pairs, or last pair with DAC_HOLD_LAST_EN.
//      clr_underrun pulse -> 0; re-asserts on the next empty frame.
//   T5 Assert reset_n=0 mid-left-slot after 5 bits -> dacdat=0, level=0 immediately.
//      After release, pushed pair appears intact at the next left slot.
//   T6 Drop enable mid-frame -> current frame ends, dacdat=0 from the next slot start, FIFO level unchanged.
//      Re-enable -> output restarts on a left slot.

Source files
------------

// File: rtl/audio_dac_tx_fifo.sv
// audio_dac_tx_fifo: stereo DAC serialiser with a sample-pair FIFO.
// Pairs from an Avalon-ST source are buffered and shifted out MSB-first on
// coe_dacdat, slaved to codec-driven bclk/daclrck (MODE 0 = I2S, 1 = LJ).
// Build option: define DAC_HOLD_LAST_EN to repeat the previous pair on
// underrun instead of sending silence.
`timescale 1ns/1ps
module audio_dac_tx_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MODE       = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [2*DATA_W-1:0]           asi_data,
  input  logic                          asi_valid,
  output logic                          asi_ready,
  input  logic                          enable,
  input  logic                          clr_underrun,
  input  logic                          coe_bclk,
  input  logic                          coe_daclrck,
  output logic                          coe_dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t              state, state_next;
  logic [1:0]          bclk_sync, lrck_sync;
  logic                bclk_d, lrck_d, lrck_seen;
  logic                bfall, lrck_rise, lrck_fall;
  logic                left_start, right_start, slot_start;
  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                full, empty, push, do_pop, set_ur;
  logic                load_left, load_right, shift_en, go_quiet;
  logic [2*DATA_W-1:0] hold, next_pair, fill_pair;
  logic [DATA_W-1:0]   shifter, load_word, load_shift;
  logic                load_bit;

  // Synchronise codec clocks; lrck is only captured on a bclk falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_d    <= 1'b0;
      lrck_d    <= 1'b0;
      lrck_seen <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], coe_bclk};
      lrck_sync <= {lrck_sync[0], coe_daclrck};
      bclk_d    <= bclk_sync[1];
      if (bfall) begin
        lrck_d    <= lrck_sync[1];
        lrck_seen <= 1'b1;
      end
    end
  end

  // lrck_seen blocks a false slot start from the reset value of lrck_d
  assign bfall       = bclk_d & ~bclk_sync[1];
  assign lrck_rise   = bfall & lrck_seen & ~lrck_d &  lrck_sync[1];
  assign lrck_fall   = bfall & lrck_seen &  lrck_d & ~lrck_sync[1];
  assign left_start  = (MODE == 1) ? lrck_rise : lrck_fall;
  assign right_start = (MODE == 1) ? lrck_fall : lrck_rise;
  assign slot_start  = lrck_rise | lrck_fall;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == FULL_LVL);
  assign empty      = (fifo_level == '0);
  assign asi_ready  = ~full;
  assign push       = asi_valid & asi_ready;
  assign do_pop     = load_left & ~empty;
  assign set_ur     = load_left & empty;

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= asi_data;
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and datapath strobes; LOAD work is done on the bfall that enters it
  always_comb begin
    state_next = state;
    load_left  = 1'b0;
    load_right = 1'b0;
    shift_en   = 1'b0;
    go_quiet   = 1'b0;
    case (state)
      IDLE: begin
        if (left_start && enable) begin
          load_left  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: state_next = SHIFT;
      SHIFT: begin
        if (slot_start && !enable) begin
          go_quiet   = 1'b1;
          state_next = IDLE;
        end else if (left_start) begin
          load_left  = 1'b1;
          state_next = LOAD;
        end else if (right_start) begin
          load_right = 1'b1;
        end else if (bfall) begin
          shift_en   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pair to latch at a left-slot start; I2S delays the MSB by one bit
  always_comb begin
`ifdef DAC_HOLD_LAST_EN
    fill_pair  = hold;
`else
    fill_pair  = '0;
`endif
    next_pair  = empty ? fill_pair : mem[rd_ptr[AW-1:0]];
    load_word  = load_left ? next_pair[2*DATA_W-1:DATA_W] : hold[DATA_W-1:0];
    load_shift = (MODE == 1) ? {load_word[DATA_W-2:0], 1'b0} : load_word;
    load_bit   = (MODE == 1) ? load_word[DATA_W-1] : 1'b0;
  end

  // Hold register, shifter and serial output; zero fill pads long slots
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold       <= '0;
      shifter    <= '0;
      coe_dacdat <= 1'b0;
    end else if (load_left) begin
      hold       <= next_pair;
      shifter    <= load_shift;
      coe_dacdat <= load_bit;
    end else if (load_right) begin
      shifter    <= load_shift;
      coe_dacdat <= load_bit;
    end else if (go_quiet) begin
      shifter    <= '0;
      coe_dacdat <= 1'b0;
    end else if (shift_en) begin
      shifter    <= {shifter[DATA_W-2:0], 1'b0};
      coe_dacdat <= shifter[DATA_W-1];
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          underrun <= 1'b0;
    else if (set_ur)       underrun <= 1'b1;
    else if (clr_underrun) underrun <= 1'b0;
  end

endmodule
